// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width and the four control-period symbols.
package tmds_pkg;

    localparam int TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/gearbox_lane.sv
// One lane of the TMDS gearbox: bit buffer, append at the shared fill point,
// and extraction of the lowest OUT_WIDTH bits as the next chunk.
module gearbox_lane
    import tmds_pkg::*;
#(
    parameter int                  IN_WIDTH  = TMDS_SYM_W,
    parameter int                  OUT_WIDTH = 2,
    parameter bit                  MSB_FIRST = 1'b0,
    parameter int                  FILL_W    = 4,
    parameter logic [IN_WIDTH-1:0] IDLE_WORD = TMDS_CTRL_00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  sym_i,
    input  logic                 accept_i,
    input  logic                 insert_i,
    input  logic                 out_en_i,
    input  logic [FILL_W-1:0]    fill_i,
    output logic [OUT_WIDTH-1:0] chunk_o
);

    localparam int BUF = IN_WIDTH + OUT_WIDTH;

    logic [IN_WIDTH-1:0]  word_raw;
    logic [IN_WIDTH-1:0]  word;
    logic [BUF-1:0]       app;
    logic [BUF-1:0]       comb;
    logic [BUF-1:0]       buf_q, buf_d;
    logic [OUT_WIDTH-1:0] chunk_q, chunk_d;

    always_comb begin
        word_raw = insert_i ? IDLE_WORD : sym_i;
        word     = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            word[i] = MSB_FIRST ? word_raw[IN_WIDTH-1-i] : word_raw[i];
        end
        // fill never exceeds OUT_WIDTH when a word is appended, so it always fits
        app  = (accept_i | insert_i) ? ({{OUT_WIDTH{1'b0}}, word} << fill_i) : '0;
        comb = buf_q | app;
        if (out_en_i) begin
            chunk_d = comb[OUT_WIDTH-1:0];
            buf_d   = comb >> OUT_WIDTH;
        end else begin
            chunk_d = chunk_q;
            buf_d   = comb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q   <= '0;
            chunk_q <= '0;
        end else begin
            buf_q   <= buf_d;
            chunk_q <= chunk_d;
        end
    end

    assign chunk_o = chunk_q;

endmodule

// File: rtl/tmds_gearbox.sv
// CHANNELS x IN_WIDTH symbol to CHANNELS x OUT_WIDTH chunk gearbox with
// valid/ready input, idle-symbol insertion on underflow and a saturating counter.
module tmds_gearbox
    import tmds_pkg::*;
#(
    parameter int                  CHANNELS  = 3,
    parameter int                  IN_WIDTH  = TMDS_SYM_W,
    parameter int                  OUT_WIDTH = 2,
    parameter bit                  MSB_FIRST = 1'b0,
    parameter logic [IN_WIDTH-1:0] IDLE_WORD = TMDS_CTRL_00,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
    input  logic                          out_en,
    output logic                          out_valid,
    output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
    output logic                          underflow,
    output logic [CNT_WIDTH-1:0]          underflow_count
);

    localparam int BUF    = IN_WIDTH + OUT_WIDTH;
    localparam int FILL_W = $clog2(BUF + 1);

    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [FILL_W-1:0]    cfill;
    logic                 out_valid_q, underflow_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept, insert;

    always_comb begin
        in_ready = (fill_q <= FILL_W'(OUT_WIDTH));
        accept   = in_valid & in_ready;
        // idle is only inserted once the buffer cannot supply a full chunk,
        // so it always lands on a symbol boundary
        insert   = out_en & (fill_q < FILL_W'(OUT_WIDTH)) & ~in_valid;
        cfill    = fill_q + ((accept | insert) ? FILL_W'(IN_WIDTH) : '0);
        fill_d   = out_en ? (cfill - FILL_W'(OUT_WIDTH)) : cfill;
        cnt_d    = (insert && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            fill_q      <= fill_d;
            out_valid_q <= out_en;
            underflow_q <= insert;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        gearbox_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .MSB_FIRST (MSB_FIRST),
            .FILL_W    (FILL_W),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .sym_i    (in_data[c*IN_WIDTH +: IN_WIDTH]),
            .accept_i (accept),
            .insert_i (insert),
            .out_en_i (out_en),
            .fill_i   (fill_q),
            .chunk_o  (out_data[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    assign out_valid       = out_valid_q;
    assign underflow       = underflow_q;
    assign underflow_count = cnt_q;

endmodule

// File: tb/tb_tmds_gearbox.sv
// Bench for tmds_gearbox: 3-lane 10->2 instance against a bit-queue model, plus
// a 10->4 instance and an MSB-first, 2-bit-counter instance with fixed tables.
module tb_tmds_gearbox;

    localparam logic [9:0] IDLE = 10'b1101010100;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    // Instance A: 3 lanes, 10 -> 2, LSB first
    logic        a_vld = 0, a_en = 0, a_rdy, a_ov, a_uf;
    logic [29:0] a_data = '0;
    logic [5:0]  a_od;
    logic [15:0] a_cnt;
    // Instance B: 1 lane, 10 -> 4
    logic        b_vld = 0, b_en = 0, b_rdy, b_ov, b_uf;
    logic [9:0]  b_data = '0;
    logic [3:0]  b_od;
    logic [15:0] b_cnt;
    // Instance C: 1 lane, 10 -> 2, MSB first, 2-bit counter
    logic        c_vld = 0, c_en = 0, c_rdy, c_ov, c_uf;
    logic [9:0]  c_data = '0;
    logic [1:0]  c_od;
    logic [1:0]  c_cnt;

    tmds_gearbox #(.CHANNELS(3)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_vld), .in_ready(a_rdy), .in_data(a_data),
        .out_en(a_en), .out_valid(a_ov), .out_data(a_od), .underflow(a_uf), .underflow_count(a_cnt));

    tmds_gearbox #(.CHANNELS(1), .OUT_WIDTH(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_vld), .in_ready(b_rdy), .in_data(b_data),
        .out_en(b_en), .out_valid(b_ov), .out_data(b_od), .underflow(b_uf), .underflow_count(b_cnt));

    tmds_gearbox #(.CHANNELS(1), .MSB_FIRST(1'b1), .CNT_WIDTH(2)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_vld), .in_ready(c_rdy), .in_data(c_data),
        .out_en(c_en), .out_valid(c_ov), .out_data(c_od), .underflow(c_uf), .underflow_count(c_cnt));

    typedef struct {
        logic [5:0] d;
        logic       uf;
        logic       v;
    } exp_t;

    logic [2:0] mq[$];     // pending bits for instance A, one entry = one bit position of all 3 lanes
    exp_t       sb_a[$];
    int         mcnt  = 0;
    logic [5:0] mlast = '0;

    task automatic cyc_a(input logic vld, input logic [29:0] data, input logic en, output logic took);
        logic rdy, ins;
        logic [2:0] bits;
        exp_t e;
        @(negedge clk);
        a_vld = vld; a_data = data; a_en = en;
        rdy = (mq.size() <= 2);
        checks++;
        if (a_rdy !== rdy) begin
            errors++; $display("FAIL a_in_ready: got %b want %b", a_rdy, rdy);
        end
        took = vld & rdy;
        ins  = en & (mq.size() < 2) & ~vld;
        if (took) for (int i = 0; i < 10; i++) mq.push_back({data[20+i], data[10+i], data[i]});
        if (ins)  for (int i = 0; i < 10; i++) mq.push_back({3{IDLE[i]}});
        if (ins && mcnt < 65535) mcnt++;
        if (en) begin
            for (int k = 0; k < 2; k++) begin
                bits = mq.pop_front();
                mlast[k] = bits[0]; mlast[2+k] = bits[1]; mlast[4+k] = bits[2];
            end
        end
        e.d = mlast; e.uf = ins; e.v = en;
        sb_a.push_back(e);
        @(posedge clk); #1;
        e = sb_a.pop_front();
        checks++;
        if (a_ov !== e.v) begin errors++; $display("FAIL a_out_valid: got %b want %b", a_ov, e.v); end
        checks++;
        if (a_od !== e.d) begin errors++; $display("FAIL a_out_data: got %h want %h", a_od, e.d); end
        checks++;
        if (a_uf !== e.uf) begin errors++; $display("FAIL a_underflow: got %b want %b", a_uf, e.uf); end
        checks++;
        if (a_cnt !== 16'(mcnt)) begin errors++; $display("FAIL a_underflow_count: got %0d want %0d", a_cnt, mcnt); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_od, a_ov, a_uf, a_cnt, b_od, b_ov, b_uf, b_cnt, c_od, c_ov, c_uf, c_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got a=%h/%b/%b/%0d b=%h/%b/%b/%0d c=%h/%b/%b/%0d want all 0",
                     a_od, a_ov, a_uf, a_cnt, b_od, b_ov, b_uf, b_cnt, c_od, c_ov, c_uf, c_cnt);
        end
        checks++;
        if ({a_rdy, b_rdy, c_rdy} !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready: got %b want 111", {a_rdy, b_rdy, c_rdy});
        end
        a_vld = 0; a_en = 0; a_data = '0;
        b_vld = 0; b_en = 0; b_data = '0;
        c_vld = 0; c_en = 0; c_data = '0;
        mq.delete(); sb_a.delete(); mcnt = 0; mlast = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic took;
        do_reset();
        cyc_a(1'b0, '0, 1'b0, took);
        cyc_a(1'b0, '0, 1'b0, took);
    endtask

    task automatic test_lsb_first();
        logic took;
        logic [1:0] want [5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11};
        logic [9:0] sym = 10'b1101001110;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc_a(i == 0, {sym, sym, sym}, 1'b1, took);
            checks++;
            if (a_od[1:0] !== want[i]) begin
                errors++; $display("FAIL lsb_chunk%0d: got %b want %b", i, a_od[1:0], want[i]);
            end
        end
        cyc_a(1'b0, '0, 1'b0, took);
    endtask

    task automatic test_idle();
        logic took;
        logic [1:0] want [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc_a(1'b0, '0, 1'b1, took);
            checks++;
            if (a_od !== {3{want[i%5]}} || a_uf !== (i % 5 == 0)) begin
                errors++; $display("FAIL idle_cycle%0d: got data %h uf %b want %h uf %b",
                                   i, a_od, a_uf, {3{want[i%5]}}, (i % 5 == 0));
            end
        end
        checks++;
        if (a_cnt !== 16'd4) begin errors++; $display("FAIL idle_count: got %0d want 4", a_cnt); end
    endtask

    task automatic test_back_to_back();
        logic took, vld, en;
        logic [29:0] cur;
        int sent = 0;
        do_reset();
        cur = {10'h3FF, 10'h2AA, 10'h155};
        for (int cyc = 0; cyc < 400 && sent < 12; cyc++) begin
            vld = ($urandom_range(0, 4) != 0);
            en  = ($urandom_range(0, 2) != 0);
            cyc_a(vld, cur, en, took);
            if (took) begin
                sent++;
                cur = 30'($urandom);
            end
        end
        checks++;
        if (sent != 12) begin errors++; $display("FAIL multi_sent: got %0d want 12", sent); end
        for (int i = 0; i < 8; i++) cyc_a(1'b0, '0, 1'b1, took);
    endtask

    task automatic test_reset_mid();
        logic took;
        do_reset();
        cyc_a(1'b1, {30{1'b1}}, 1'b1, took);
        cyc_a(1'b0, '0, 1'b1, took);
        do_reset();
        cyc_a(1'b0, '0, 1'b1, took);
        checks++;
        if (a_od !== 6'b000000 || a_uf !== 1'b1) begin
            errors++; $display("FAIL reset_mid_first: got %h uf %b want 00 uf 1", a_od, a_uf);
        end
        cyc_a(1'b0, '0, 1'b1, took);
        checks++;
        if (a_od !== 6'b010101) begin errors++; $display("FAIL reset_mid_second: got %b want 010101", a_od); end
    endtask

    task automatic test_ratio_10_4();
        logic       vt [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [9:0] dt [5] = '{10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000};
        logic       rt [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] ct [5] = '{4'hF, 4'hF, 4'h3, 4'h0, 4'h0};
        logic [3:0] sb_b[$];
        logic [3:0] w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_vld = vt[i]; b_data = dt[i]; b_en = 1'b1;
            checks++;
            if (b_rdy !== rt[i]) begin errors++; $display("FAIL b_in_ready%0d: got %b want %b", i, b_rdy, rt[i]); end
            sb_b.push_back(ct[i]);
            @(posedge clk); #1;
            w = sb_b.pop_front();
            checks++;
            if (b_od !== w || b_ov !== 1'b1 || b_uf !== 1'b0) begin
                errors++; $display("FAIL b_chunk%0d: got %h v%b uf%b want %h v1 uf0", i, b_od, b_ov, b_uf, w);
            end
        end
        @(negedge clk);
        b_vld = 0; b_en = 0;
    endtask

    task automatic test_msb_sat();
        logic [1:0] idle_rev [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [1:0] sb_d[$];
        logic [1:0] sb_n[$];
        logic       sb_u[$];
        logic [1:0] wd, wn;
        logic       wu;
        int         ins = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            c_vld = (i == 0); c_data = 10'b1000000000; c_en = 1'b1;
            if (i < 5) begin
                sb_d.push_back(i == 0 ? 2'b01 : 2'b00);
                sb_u.push_back(1'b0);
            end else begin
                sb_d.push_back(idle_rev[(i-5)%5]);
                sb_u.push_back((i - 5) % 5 == 0);
                if ((i - 5) % 5 == 0) ins++;
            end
            sb_n.push_back(ins > 3 ? 2'd3 : 2'(ins));
            @(posedge clk); #1;
            wd = sb_d.pop_front(); wu = sb_u.pop_front(); wn = sb_n.pop_front();
            checks++;
            if (c_od !== wd || c_uf !== wu || c_cnt !== wn) begin
                errors++; $display("FAIL c_cycle%0d: got %b uf%b cnt%0d want %b uf%b cnt%0d",
                                   i, c_od, c_uf, c_cnt, wd, wu, wn);
            end
        end
        @(negedge clk);
        c_vld = 0; c_en = 0;
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        test_ratio_10_4();
        test_msb_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_gearbox.md
Name: tmds_gearbox

Overview:
- Parametrised single-clock bit gearbox: converts lockstep CHANNELS x IN_WIDTH parallel symbols (TMDS 10-bit by default) into CHANNELS x OUT_WIDTH-bit chunks, one chunk per enabled cycle.
- Supports non-integer ratios (e.g. 10->4), has valid/ready input flow control and inserts an idle symbol on underflow.
- Sits between the TMDS encoders and the output serialiser primitives, so the primitive ratio can differ from the symbol width.

Parameters:
- CHANNELS, 3, lanes processed in lockstep; lane c occupies in_data[c*IN_WIDTH +: IN_WIDTH] and out_data[c*OUT_WIDTH +: OUT_WIDTH].
- IN_WIDTH, 10, bits per input symbol (>=1).
- OUT_WIDTH, 2, bits emitted per lane per enabled cycle (1..IN_WIDTH).
- MSB_FIRST, 0, when 1 each input symbol is bit-reversed before buffering; 0 means LSB transmitted first.
- IDLE_WORD, 10'b1101010100, symbol inserted into every lane on underflow (TMDS control 00).
- CNT_WIDTH, 16, underflow counter width.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  in_data holds a symbol for all lanes
- in_ready  out  1  gearbox accepts a symbol this cycle
- in_data  in  CHANNELS*IN_WIDTH  lane symbols
- out_en  in  1  consumer takes one chunk this cycle
- out_valid  out  1  out_data updated by the previous enabled cycle
- out_data  out  CHANNELS*OUT_WIDTH  output chunks, bit 0 of a lane is transmitted first
- underflow  out  1  one-cycle pulse when an idle symbol was inserted
- underflow_count  out  CNT_WIDTH  saturating count of insertions

Behaviour:
- State is a per-lane bit buffer of BUF = IN_WIDTH+OUT_WIDTH bits plus a shared fill counter (0..BUF). Valid bits sit at positions [0, fill).
- Reset (async, any time): fill=0, buffers=0, out_data=0, out_valid=0, underflow=0, underflow_count=0. Any partial symbol is discarded.
- in_ready = (fill <= OUT_WIDTH). It depends on registered state only, never on in_valid or out_en.
- accept = in_valid & in_ready. The symbol (reversed if MSB_FIRST) is appended at bit position fill.
- insert = out_en & (fill < OUT_WIDTH) & !in_valid. IDLE_WORD (same reversal rule) is appended at position fill in every lane.
  - If fill < OUT_WIDTH then in_ready=1, so accept and insert are mutually exclusive.
- Combined view per cycle: comb = buffer | (appended word << fill); cfill = fill + (accept|insert ? IN_WIDTH : 0).
- If out_en: out_data lane <= comb[OUT_WIDTH-1:0]; buffer <= comb >> OUT_WIDTH; fill <= cfill - OUT_WIDTH; out_valid <= 1.
- If !out_en: buffer <= comb; fill <= cfill; out_data holds its value; out_valid <= 0.
- Latency: a chunk appears on out_data the cycle after the enabled cycle that consumed it.
- In-order guarantee: symbol boundaries are preserved, so idle symbols are only ever inserted whole, never mid-symbol.
- underflow <= insert. underflow_count increments on insert and saturates at all-ones.
- First enabled cycle after reset with no in_valid: counts as an underflow and inserts an idle symbol.
- in_valid while !in_ready: the symbol is not taken and the upstream must hold it. in_data is not sampled.
- All lanes share fill, accept and insert; lanes never slip relative to each other.

Decomposition:
- Package tmds_pkg: TMDS_CTRL_00..11 idle/control symbol constants and the TMDS symbol width constant, shared with the encoders.
- One sub-module, gearbox_lane: per-lane buffer, append shift and chunk extraction, driven by shared fill/accept/insert. The top module holds fill, handshake, counter and a generate loop over CHANNELS.

Test Plan:
- Defaults, CHANNELS=1, send 10'b1101001110 with out_en held high -> out_data chunks 2'b10, 2'b11, 2'b00, 2'b01, 2'b11 on five consecutive cycles, each one cycle after its consuming edge; no underflow.
- OUT_WIDTH=4, words 10'h3FF then 10'h000 back-to-back, out_en high -> chunks 4'hF, 4'hF, 4'h3, 4'h0, 4'h0; in_ready low whenever fill>4.
- Defaults, out_en high, in_valid low for 20 cycles from reset -> IDLE_WORD serialised as 00,01,01,01,11 repeatedly; underflow pulses every 5 cycles; underflow_count=4.
- CHANNELS=3 with distinct symbols 10'h155/10'h2AA/10'h3FF, random out_en gaps -> each lane reconstructs its exact stream; out_valid low after each !out_en cycle; lanes stay aligned.
- MSB_FIRST=1, 10'b1000000000 -> first chunk 2'b01. Reset asserted mid-symbol -> all outputs 0 immediately (asynchronously), and the next enabled cycle emits IDLE bits.
- CNT_WIDTH=2 with continuous underflow -> underflow_count saturates at 3 and holds.
